// File: rtl/pipeline_debug_ctrl_if.sv
// Host-side bundle for the pipeline run-control block: command and program-load
// handshakes plus the instruction-memory write port the controller drives.
interface pipeline_debug_ctrl_if #(
    parameter int ADDR_W = 5
);
    logic              cmd_valid;
    logic [1:0]        cmd_code;
    logic              cmd_ready;
    logic              load_valid;
    logic [31:0]       load_data;
    logic              load_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output cmd_valid, cmd_code, load_valid, load_data,
        input  cmd_ready, load_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  cmd_valid, cmd_code, load_valid, load_data,
        output cmd_ready, load_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/pipeline_debug_ctrl.sv
// Run-control front end for the 5-stage pipeline: program load, run/step gating, HALT drain.
// Optional run-cycle limit is built in when DEBUG_CYCLE_LIMIT_EN is defined.
module pipeline_debug_ctrl #(
    parameter int          ADDR_W       = 5,
    parameter logic [31:0] HALT_INSTR   = 32'hFFFF_FFFF,
    parameter int          DRAIN_CYCLES = 4,
    parameter logic [31:0] MAX_CYCLES   = 32'd1000
) (
    input  logic                        clk,
    input  logic                        reset,
    pipeline_debug_ctrl_if.slave        bus,
    input  logic [31:0]                 instr_if,
    output logic                        pipe_ena,
    output logic                        pipe_reset,
    output logic [31:0]                 cycle_count,
    output logic                        halted,
    output logic                        timeout
);
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_STEP   = 3'd4,
        ST_HALTED = 3'd5,
        ST_RSTSEQ = 3'd6
    } state_e;

    localparam logic [1:0] CMD_LOAD  = 2'd0;
    localparam logic [1:0] CMD_RUN   = 2'd1;
    localparam logic [1:0] CMD_STEP  = 2'd2;
    localparam int         DW        = $clog2(DRAIN_CYCLES + 2);
    localparam logic [DW-1:0]     DRAIN_INIT = DW'(DRAIN_CYCLES);
    localparam logic [ADDR_W-1:0] ADDR_LAST  = {ADDR_W{1'b1}};
    localparam bit                NO_DRAIN   = (DRAIN_CYCLES == 0);

    state_e            state_q, state_d;
    logic [DW-1:0]     drain_cnt_q, drain_cnt_d;
    logic [ADDR_W-1:0] load_addr_q, load_addr_d;
    logic [31:0]       cycle_count_q, cycle_count_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              load_ready_q, load_ready_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              pipe_ena_q, pipe_ena_d;
    logic              pipe_reset_q, pipe_reset_d;
    logic              halted_q, halted_d;
    logic              timeout_q, timeout_d;
    logic              cmd_acc_s, load_acc_s, clr_s;
    logic [31:0]       cnt_inc_s;

    // Next-state and registered-output computation.
    always_comb begin
        cmd_acc_s     = bus.cmd_valid & cmd_ready_q;
        load_acc_s    = bus.load_valid & load_ready_q;
        cnt_inc_s     = (cycle_count_q == 32'hFFFF_FFFF) ? cycle_count_q : cycle_count_q + 32'd1;
        state_d       = state_q;
        drain_cnt_d   = drain_cnt_q;
        load_addr_d   = load_addr_q;
        cycle_count_d = pipe_ena_q ? cnt_inc_s : cycle_count_q;
        imem_we_d     = 1'b0;
        imem_addr_d   = imem_addr_q;
        imem_wdata_d  = imem_wdata_q;
        timeout_d     = timeout_q;
        clr_s         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_acc_s) begin
                    case (bus.cmd_code)
                        CMD_LOAD: begin state_d = ST_LOAD;   clr_s = 1'b1; end
                        CMD_RUN:  begin state_d = ST_RUN;                  end
                        CMD_STEP: begin state_d = ST_STEP;                 end
                        default:  begin state_d = ST_RSTSEQ; clr_s = 1'b1; end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (load_acc_s) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = load_addr_q;
                    imem_wdata_d = bus.load_data;
                    // The terminator word is still written; the last address never wraps.
                    if ((bus.load_data == HALT_INSTR) || (load_addr_q == ADDR_LAST)) begin
                        state_d = ST_IDLE;
                    end else begin
                        load_addr_d = load_addr_q + ADDR_W'(1);
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (cmd_acc_s && (bus.cmd_code == 2'd3)) begin
                    state_d = ST_RSTSEQ;
                    clr_s   = 1'b1;
                end else if (pipe_ena_q && (instr_if == HALT_INSTR)) begin
                    if (NO_DRAIN) begin
                        state_d = ST_HALTED;
                    end else begin
                        state_d     = ST_DRAIN;
                        drain_cnt_d = DRAIN_INIT;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q <= DW'(1)) begin
                    state_d = ST_HALTED;
                end else begin
                    drain_cnt_d = drain_cnt_q - DW'(1);
                end
            end
            ST_STEP: state_d = ST_IDLE;
            ST_HALTED: begin
                if (cmd_acc_s && (bus.cmd_code == CMD_LOAD)) begin
                    state_d = ST_LOAD;
                    clr_s   = 1'b1;
                end else if (cmd_acc_s && (bus.cmd_code == 2'd3)) begin
                    state_d = ST_RSTSEQ;
                    clr_s   = 1'b1;
                end else begin
                    state_d = ST_HALTED;
                end
            end
            ST_RSTSEQ: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

`ifdef DEBUG_CYCLE_LIMIT_EN
        // A command-driven reset outranks the limit; otherwise stop once the count reaches it.
        if (((state_q == ST_RUN) || (state_q == ST_DRAIN)) && (state_d != ST_RSTSEQ)
            && (cycle_count_d >= MAX_CYCLES)) begin
            state_d   = ST_HALTED;
            timeout_d = 1'b1;
        end else begin
            timeout_d = timeout_q;
        end
`else
        timeout_d = 1'b0;
`endif

        if (clr_s) begin
            load_addr_d   = {ADDR_W{1'b0}};
            cycle_count_d = 32'd0;
            timeout_d     = 1'b0;
        end else begin
            load_addr_d   = load_addr_d;
        end

        pipe_ena_d   = (state_d == ST_RUN) || (state_d == ST_DRAIN) || (state_d == ST_STEP);
        pipe_reset_d = (state_d == ST_RSTSEQ);
        cmd_ready_d  = (state_d == ST_IDLE) || (state_d == ST_RUN) || (state_d == ST_HALTED);
        load_ready_d = (state_d == ST_LOAD);
        halted_d     = (state_d == ST_HALTED);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            drain_cnt_q   <= {DW{1'b0}};
            load_addr_q   <= {ADDR_W{1'b0}};
            cycle_count_q <= 32'd0;
            cmd_ready_q   <= 1'b0;
            load_ready_q  <= 1'b0;
            imem_we_q     <= 1'b0;
            imem_addr_q   <= {ADDR_W{1'b0}};
            imem_wdata_q  <= 32'd0;
            pipe_ena_q    <= 1'b0;
            pipe_reset_q  <= 1'b1;
            halted_q      <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            drain_cnt_q   <= drain_cnt_d;
            load_addr_q   <= load_addr_d;
            cycle_count_q <= cycle_count_d;
            cmd_ready_q   <= cmd_ready_d;
            load_ready_q  <= load_ready_d;
            imem_we_q     <= imem_we_d;
            imem_addr_q   <= imem_addr_d;
            imem_wdata_q  <= imem_wdata_d;
            pipe_ena_q    <= pipe_ena_d;
            pipe_reset_q  <= pipe_reset_d;
            halted_q      <= halted_d;
            timeout_q     <= timeout_d;
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.load_ready = load_ready_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign pipe_ena       = pipe_ena_q;
    assign pipe_reset     = pipe_reset_q;
    assign cycle_count    = cycle_count_q;
    assign halted         = halted_q;
    assign timeout        = timeout_q;
endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// Scoreboard bench for pipeline_debug_ctrl: expected imem writes and enabled-cycle counts
// are queued by the stimulus and popped by a negedge monitor.
module tb_pipeline_debug_ctrl;
    localparam logic [1:0]  C_LOAD = 2'd0, C_RUN = 2'd1, C_STEP = 2'd2, C_RESET = 2'd3;
    localparam logic [31:0] HALT   = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instr_if = 32'd0;
    logic        pipe_ena, pipe_reset, halted, timeout;
    logic [31:0] cycle_count;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [36:0] imem_q[$];
    logic [31:0] ena_q[$];

    pipeline_debug_ctrl_if #(.ADDR_W(5)) bus ();

    pipeline_debug_ctrl #(
        .ADDR_W(5), .HALT_INSTR(HALT), .DRAIN_CYCLES(4), .MAX_CYCLES(32'd20)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .instr_if(instr_if),
        .pipe_ena(pipe_ena), .pipe_reset(pipe_reset), .cycle_count(cycle_count),
        .halted(halted), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] code);
        int n;
        n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_code  = code;
        while (!bus.cmd_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("cmd_ready_timeout", 32'(n), 32'd0);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic load_word(input logic [31:0] d);
        int n;
        n = 0;
        bus.load_valid = 1'b1;
        bus.load_data  = d;
        while (!bus.load_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("load_ready_timeout", 32'(n), 32'd0);
        tick();
        bus.load_valid = 1'b0;
    endtask

    // Monitor: every write strobe and every enabled cycle must match the next queued expectation.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.imem_we) begin
                if (imem_q.size() == 0) chk("imem_unexpected", {27'd0, bus.imem_addr}, 32'hDEAD_0000);
                else begin
                    logic [36:0] e;
                    e = imem_q.pop_front();
                    chk("imem_addr", {27'd0, bus.imem_addr}, {27'd0, e[36:32]});
                    chk("imem_wdata", bus.imem_wdata, e[31:0]);
                end
            end
            if (pipe_ena) begin
                if (ena_q.size() == 0) chk("ena_unexpected", cycle_count, 32'hDEAD_0001);
                else chk("ena_cycle_count", cycle_count, ena_q.pop_front());
            end
        end
    end

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_code = 2'd0; bus.load_valid = 1'b0; bus.load_data = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        chk("rst_load_ready", {31'd0, bus.load_ready}, 32'd0);
        chk("rst_imem", {bus.imem_we, bus.imem_addr, bus.imem_wdata[25:0]}, 32'd0);
        chk("rst_pipe", {30'd0, pipe_ena, pipe_reset}, 32'd1);
        chk("rst_status", {cycle_count[29:0], halted, timeout}, 32'd0);
        reset = 1'b1;
        #1 chk("rel_pipe_reset_held", {31'd0, pipe_reset}, 32'd1);
        tick();
        chk("rel_pipe_reset", {31'd0, pipe_reset}, 32'd0);
        chk("rel_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);

        // Program load terminated by the HALT word.
        imem_q.push_back({5'd0, 32'h2001_0005});
        imem_q.push_back({5'd1, 32'h2002_0007});
        imem_q.push_back({5'd2, HALT});
        send_cmd(C_LOAD);
        chk("load_ready_in_load", {31'd0, bus.load_ready}, 32'd1);
        load_word(32'h2001_0005);
        load_word(32'h2002_0007);
        load_word(HALT);
        chk("load_ready_drop", {31'd0, bus.load_ready}, 32'd0);
        chk("load_idle_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        tick();

        // RUN with HALT at IF on the 10th enabled cycle, then a 4-cycle drain.
        for (int i = 0; i < 14; i++) ena_q.push_back(32'(i));
        send_cmd(C_RUN);
        repeat (9) tick();
        instr_if = HALT;
        tick();
        instr_if = 32'd0;
        chk("drain_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        repeat (4) tick();
        chk("halt_halted", {31'd0, halted}, 32'd1);
        chk("halt_count", cycle_count, 32'd14);
        chk("halt_ena", {31'd0, pipe_ena}, 32'd0);
        chk("halt_timeout", {31'd0, timeout}, 32'd0);
        send_cmd(C_STEP);
        chk("halted_ignores_step", {30'd0, halted, pipe_ena}, 32'd2);

        // RESET from HALTED.
        send_cmd(C_RESET);
        chk("rseq_pipe", {30'd0, pipe_ena, pipe_reset}, 32'd1);
        chk("rseq_status", {cycle_count[30:0], halted}, 32'd0);
        tick();
        chk("rseq_done", {30'd0, pipe_reset, bus.cmd_ready}, 32'd1);

        // Three single steps.
        for (int i = 0; i < 3; i++) begin
            ena_q.push_back(32'(i));
            send_cmd(C_STEP);
        end
        tick();
        chk("step_count", cycle_count, 32'd3);
        chk("step_idle", {30'd0, pipe_ena, bus.cmd_ready}, 32'd1);

        // RESET accepted while RUN is at cycle_count=7.
        for (int i = 3; i < 8; i++) ena_q.push_back(32'(i));
        send_cmd(C_RUN);
        repeat (4) tick();
        chk("run_pre_reset_count", cycle_count, 32'd7);
        send_cmd(C_RESET);
        chk("run_reset_pipe", {30'd0, pipe_ena, pipe_reset}, 32'd1);
        chk("run_reset_count", cycle_count, 32'd0);
        tick();
        chk("run_reset_idle", {30'd0, pipe_reset, bus.cmd_ready}, 32'd1);

        // Full-memory load with no terminator stops after the last address.
        for (int i = 0; i < 32; i++) imem_q.push_back({5'(i), 32'h1000_0000 + 32'(i)});
        send_cmd(C_LOAD);
        for (int i = 0; i < 32; i++) load_word(32'h1000_0000 + 32'(i));
        chk("full_load_ready", {31'd0, bus.load_ready}, 32'd0);
        chk("full_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        tick();
        chk("full_no_extra_we", {31'd0, bus.imem_we}, 32'd0);

        // Async reset drops an in-flight write.
        send_cmd(C_LOAD);
        load_word(32'hABCD_0001);
        reset = 1'b0;
        #1;
        chk("async_imem_we", {31'd0, bus.imem_we}, 32'd0);
        chk("async_pipe_reset", {30'd0, pipe_reset, bus.load_ready}, 32'd2);
        tick();
        reset = 1'b1;
        tick();

`ifdef DEBUG_CYCLE_LIMIT_EN
        for (int i = 0; i < 20; i++) ena_q.push_back(32'(i));
        send_cmd(C_RUN);
        begin
            int n;
            n = 0;
            while (!halted && n < 100) begin
                tick();
                n++;
            end
            chk("limit_wait", {31'd0, halted}, 32'd1);
        end
        chk("limit_count", cycle_count, 32'd20);
        chk("limit_timeout", {30'd0, timeout, pipe_ena}, 32'd2);
        send_cmd(C_RESET);
        chk("limit_timeout_clr", {31'd0, timeout}, 32'd0);
`else
        for (int i = 0; i < 25; i++) ena_q.push_back(32'(i));
        send_cmd(C_RUN);
        repeat (24) tick();
        chk("nolimit_count", cycle_count, 32'd24);
        chk("nolimit_running", {29'd0, timeout, halted, pipe_ena}, 32'd1);
        send_cmd(C_RESET);
        chk("nolimit_reset", {30'd0, pipe_ena, pipe_reset}, 32'd1);
`endif
        repeat (3) tick();
        chk("imem_queue_empty", 32'(imem_q.size()), 32'd0);
        chk("ena_queue_empty", 32'(ena_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
